// File: rtl/exec_trace_if.sv
// Signal bundle between the execution-trace checker and its host: table
// configuration, run control, CPU observation and run status.
interface exec_trace_if #(
    parameter int PC_W   = 9,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int IDX_W  = $clog2(DEPTH)
);
    logic              cfg_we;
    logic [IDX_W-1:0]  cfg_addr;
    logic [PC_W-1:0]   cfg_pc;
    logic [DATA_W-1:0] cfg_data;
    logic              cfg_chk;
    logic [IDX_W:0]    num_entries;
    logic              start;
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] probe_data;
    logic              busy;
    logic              done;
    logic              err;
    logic [1:0]        err_kind;
    logic [IDX_W-1:0]  err_idx;
    logic [IDX_W:0]    event_count;

    modport master (
        output cfg_we, cfg_addr, cfg_pc, cfg_data, cfg_chk, num_entries, start,
               pc, probe_data,
        input  busy, done, err, err_kind, err_idx, event_count
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_pc, cfg_data, cfg_chk, num_entries, start,
               pc, probe_data,
        output busy, done, err, err_kind, err_idx, event_count
    );
endinterface

// File: rtl/exec_trace_checker.sv
// Execution-trace checker: compares each PC change against a loadable table of
// expected (PC, data) events, then confirms the CPU halts.
module exec_trace_checker #(
    parameter int PC_W        = 9,
    parameter int DATA_W      = 16,
    parameter int DEPTH       = 8,
    parameter int IDX_W       = $clog2(DEPTH),
    parameter int HALT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    exec_trace_if.slave bus
);
    localparam int SC_W = $clog2(HALT_CYCLES);
    localparam logic [SC_W-1:0] STALL_MAX = SC_W'(HALT_CYCLES - 1);
    localparam logic [IDX_W:0]  DEPTH_C   = (IDX_W + 1)'(DEPTH);

    localparam logic [1:0] KIND_PC    = 2'd0;
    localparam logic [1:0] KIND_DATA  = 2'd1;
    localparam logic [1:0] KIND_STALL = 2'd2;
    localparam logic [1:0] KIND_LATE  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RUN      = 3'd1,
        ST_HALTWAIT = 3'd2,
        ST_DONE     = 3'd3,
        ST_ERROR    = 3'd4
    } state_t;

    // Expected-event table; deliberately not reset
    logic [PC_W-1:0]   r_tbl_pc   [DEPTH];
    logic [DATA_W-1:0] r_tbl_data [DEPTH];
    logic              r_tbl_chk  [DEPTH];

    state_t            r_state;
    logic [PC_W-1:0]   r_pc_last;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W:0]    r_n;
    logic [SC_W-1:0]   r_stall_cnt;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic [1:0]        r_err_kind;
    logic [IDX_W-1:0]  r_err_idx;
    logic [IDX_W:0]    r_event_count;

    state_t            w_state_nxt;
    logic [PC_W-1:0]   w_pc_last_nxt;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic [IDX_W:0]    w_n_nxt;
    logic [SC_W-1:0]   w_stall_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;
    logic              w_err_nxt;
    logic [1:0]        w_err_kind_nxt;
    logic [IDX_W-1:0]  w_err_idx_nxt;
    logic [IDX_W:0]    w_event_count_nxt;

    logic              w_cfg_open;
    logic              w_pc_changed;
    logic [SC_W-1:0]   w_stall_inc;
    logic [IDX_W:0]    w_n_start;
    logic [IDX_W-1:0]  w_last_idx;

    assign w_cfg_open   = (r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERROR);
    assign w_pc_changed = (bus.pc != r_pc_last);
    assign w_stall_inc  = r_stall_cnt + SC_W'(1);
    assign w_n_start    = (bus.num_entries > DEPTH_C) ? DEPTH_C : bus.num_entries;
    // n=0 reports a late change against entry 0
    assign w_last_idx   = (r_n == (IDX_W + 1)'(0)) ? IDX_W'(0) : IDX_W'(r_n - (IDX_W + 1)'(1));

    // Table load port, open only while no run is in progress
    always_ff @(posedge clk) begin
        if (bus.cfg_we && w_cfg_open) begin
            r_tbl_pc[bus.cfg_addr]   <= bus.cfg_pc;
            r_tbl_data[bus.cfg_addr] <= bus.cfg_data;
            r_tbl_chk[bus.cfg_addr]  <= bus.cfg_chk;
        end
    end

    // Next-state and next-output logic of the check FSM
    always_comb begin
        w_state_nxt       = r_state;
        w_pc_last_nxt     = r_pc_last;
        w_idx_nxt         = r_idx;
        w_n_nxt           = r_n;
        w_stall_nxt       = r_stall_cnt;
        w_done_nxt        = r_done;
        w_err_nxt         = r_err;
        w_err_kind_nxt    = r_err_kind;
        w_err_idx_nxt     = r_err_idx;
        w_event_count_nxt = r_event_count;

        case (r_state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (bus.start) begin
                    w_pc_last_nxt     = bus.pc;
                    w_idx_nxt         = IDX_W'(0);
                    w_event_count_nxt = (IDX_W + 1)'(0);
                    w_stall_nxt       = SC_W'(0);
                    w_n_nxt           = w_n_start;
                    w_done_nxt        = 1'b0;
                    w_err_nxt         = 1'b0;
                    if (w_n_start != (IDX_W + 1)'(0)) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_state_nxt = ST_HALTWAIT;
                    end
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_RUN: begin
                if (w_pc_changed) begin
                    // PC check outranks the data check on the same event
                    if (bus.pc != r_tbl_pc[r_idx]) begin
                        w_state_nxt    = ST_ERROR;
                        w_err_nxt      = 1'b1;
                        w_err_kind_nxt = KIND_PC;
                        w_err_idx_nxt  = r_idx;
                    end else if (r_tbl_chk[r_idx] && (bus.probe_data != r_tbl_data[r_idx])) begin
                        w_state_nxt    = ST_ERROR;
                        w_err_nxt      = 1'b1;
                        w_err_kind_nxt = KIND_DATA;
                        w_err_idx_nxt  = r_idx;
                    end else begin
                        w_event_count_nxt = r_event_count + (IDX_W + 1)'(1);
                        w_pc_last_nxt     = bus.pc;
                        w_stall_nxt       = SC_W'(0);
                        w_idx_nxt         = r_idx + IDX_W'(1);
                        if (r_idx == w_last_idx) begin
                            w_state_nxt = ST_HALTWAIT;
                        end else begin
                            w_state_nxt = ST_RUN;
                        end
                    end
                end else if (w_stall_inc == STALL_MAX) begin
                    w_state_nxt    = ST_ERROR;
                    w_err_nxt      = 1'b1;
                    w_err_kind_nxt = KIND_STALL;
                    w_err_idx_nxt  = r_idx;
                end else begin
                    w_stall_nxt = w_stall_inc;
                end
            end
            ST_HALTWAIT: begin
                // DONE lands exactly HALT_CYCLES edges after entering this state
                if (w_pc_changed) begin
                    w_state_nxt    = ST_ERROR;
                    w_err_nxt      = 1'b1;
                    w_err_kind_nxt = KIND_LATE;
                    w_err_idx_nxt  = w_last_idx;
                end else if (r_stall_cnt == STALL_MAX) begin
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_stall_nxt = w_stall_inc;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt == ST_RUN) || (w_state_nxt == ST_HALTWAIT);
    end

    // State and registered-output update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_pc_last     <= '0;
            r_idx         <= '0;
            r_n           <= '0;
            r_stall_cnt   <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_err_kind    <= 2'd0;
            r_err_idx     <= '0;
            r_event_count <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc_last     <= w_pc_last_nxt;
            r_idx         <= w_idx_nxt;
            r_n           <= w_n_nxt;
            r_stall_cnt   <= w_stall_nxt;
            r_busy        <= w_busy_nxt;
            r_done        <= w_done_nxt;
            r_err         <= w_err_nxt;
            r_err_kind    <= w_err_kind_nxt;
            r_err_idx     <= w_err_idx_nxt;
            r_event_count <= w_event_count_nxt;
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.err         = r_err;
    assign bus.err_kind    = r_err_kind;
    assign bus.err_idx     = r_err_idx;
    assign bus.event_count = r_event_count;
endmodule

// File: tb/tb_exec_trace_checker.sv
// Directed bench for exec_trace_checker: pass path, each error kind, n=0,
// clamping, mid-run reset and configuration lockout.
module tb_exec_trace_checker;
    localparam int PC_W        = 9;
    localparam int DATA_W      = 16;
    localparam int DEPTH       = 8;
    localparam int IDX_W       = $clog2(DEPTH);
    localparam int HALT_CYCLES = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    exec_trace_if #(.PC_W(PC_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) bus ();

    exec_trace_checker #(
        .PC_W(PC_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W), .HALT_CYCLES(HALT_CYCLES)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] good_data(input int pc);
        if (pc == 2)      return 16'd5;
        else if (pc == 3) return 16'hABCD;
        else              return 16'd0;
    endfunction

    task automatic write_entry(input int addr, input int pc, input int data, input logic chk);
        bus.cfg_addr = IDX_W'(addr);
        bus.cfg_pc   = PC_W'(pc);
        bus.cfg_data = DATA_W'(data);
        bus.cfg_chk  = chk;
        bus.cfg_we   = 1'b1;
        tick();
        bus.cfg_we   = 1'b0;
    endtask

    task automatic start_run(input int n);
        bus.pc          = 9'd0;
        bus.probe_data  = 16'd0;
        bus.num_entries = (IDX_W + 1)'(n);
        bus.start       = 1'b1;
        tick();
        bus.start       = 1'b0;
    endtask

    task automatic drive(input int pc, input int data);
        bus.pc         = PC_W'(pc);
        bus.probe_data = DATA_W'(data);
        tick();
    endtask

    task automatic run_good(input int last_pc);
        for (int p = 1; p <= last_pc; p++) drive(p, good_data(p));
    endtask

    task automatic wait_end(input int max_ticks, output int t);
        t = 0;
        while (!(bus.done || bus.err) && t < max_ticks) begin
            tick();
            t++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        n_checks++;
        if ({bus.busy, bus.done, bus.err, bus.err_kind, bus.err_idx, bus.event_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_values: got busy=%0b done=%0b err=%0b kind=%0d idx=%0d cnt=%0d, want all 0",
                     bus.busy, bus.done, bus.err, bus.err_kind, bus.err_idx, bus.event_count);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_pass();
        bit early = 1'b0;
        start_run(5);
        n_checks++;
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL pass_busy_rise: got %0b want 1", bus.busy); end
        run_good(5);
        n_checks++;
        if (bus.event_count !== 4'd5) begin n_fail++; $display("FAIL pass_event_count: got %0d want 5", bus.event_count); end
        for (int i = 1; i <= HALT_CYCLES; i++) begin
            tick();
            if (i < HALT_CYCLES && (bus.done !== 1'b0 || bus.busy !== 1'b1)) early = 1'b1;
        end
        n_checks++;
        if (early !== 1'b0) begin n_fail++; $display("FAIL pass_haltwait_len: done/busy changed before %0d cycles", HALT_CYCLES); end
        n_checks++;
        if ({bus.done, bus.err, bus.busy} !== 3'b100) begin
            n_fail++;
            $display("FAIL pass_done: got done=%0b err=%0b busy=%0b want 1 0 0", bus.done, bus.err, bus.busy);
        end
    endtask

    task automatic test_pc_mismatch();
        start_run(5);
        n_checks++;
        if (bus.done !== 1'b0) begin n_fail++; $display("FAIL restart_clears_done: got %0b want 0", bus.done); end
        run_good(2);
        drive(4, 0);
        n_checks++;
        if ({bus.err, bus.err_kind, bus.err_idx, bus.busy, bus.done} !== {1'b1, 2'd0, 3'd2, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL pc_mismatch: got err=%0b kind=%0d idx=%0d busy=%0b done=%0b want 1 0 2 0 0",
                     bus.err, bus.err_kind, bus.err_idx, bus.busy, bus.done);
        end
        n_checks++;
        if (bus.event_count !== 4'd2) begin n_fail++; $display("FAIL pc_mismatch_count: got %0d want 2", bus.event_count); end
    endtask

    task automatic test_data_mismatch();
        start_run(5);
        run_good(2);
        drive(3, 16'hABCC);
        n_checks++;
        if ({bus.err, bus.err_kind, bus.err_idx} !== {1'b1, 2'd1, 3'd2}) begin
            n_fail++;
            $display("FAIL data_mismatch_e2: got err=%0b kind=%0d idx=%0d want 1 1 2", bus.err, bus.err_kind, bus.err_idx);
        end
        start_run(5);
        run_good(1);
        drive(2, 6);
        n_checks++;
        if ({bus.err, bus.err_kind, bus.err_idx} !== {1'b1, 2'd1, 3'd1}) begin
            n_fail++;
            $display("FAIL data_mismatch_e1: got err=%0b kind=%0d idx=%0d want 1 1 1", bus.err, bus.err_kind, bus.err_idx);
        end
        start_run(5);
        run_good(2);
        drive(4, 16'hABCC);
        n_checks++;
        if ({bus.err, bus.err_kind, bus.err_idx} !== {1'b1, 2'd0, 3'd2}) begin
            n_fail++;
            $display("FAIL pc_and_data_priority: got err=%0b kind=%0d idx=%0d want 1 0 2", bus.err, bus.err_kind, bus.err_idx);
        end
    endtask

    task automatic test_stall();
        int t;
        start_run(5);
        run_good(2);
        wait_end(40, t);
        n_checks++;
        if ({bus.err, bus.err_kind, bus.err_idx} !== {1'b1, 2'd2, 3'd2}) begin
            n_fail++;
            $display("FAIL stall_timeout: got err=%0b kind=%0d idx=%0d want 1 2 2", bus.err, bus.err_kind, bus.err_idx);
        end
        n_checks++;
        if (t < HALT_CYCLES - 1 || t > HALT_CYCLES) begin
            n_fail++;
            $display("FAIL stall_latency: got %0d cycles want %0d..%0d", t, HALT_CYCLES - 1, HALT_CYCLES);
        end
    endtask

    task automatic test_late_change();
        start_run(5);
        run_good(5);
        tick();
        tick();
        tick();
        drive(6, 0);
        n_checks++;
        if ({bus.err, bus.err_kind, bus.err_idx, bus.done} !== {1'b1, 2'd3, 3'd4, 1'b0}) begin
            n_fail++;
            $display("FAIL late_change: got err=%0b kind=%0d idx=%0d done=%0b want 1 3 4 0",
                     bus.err, bus.err_kind, bus.err_idx, bus.done);
        end
    endtask

    task automatic test_zero_entries();
        int t;
        start_run(0);
        n_checks++;
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL zero_busy: got %0b want 1", bus.busy); end
        wait_end(40, t);
        n_checks++;
        if ({bus.done, bus.err, t} !== {1'b1, 1'b0, HALT_CYCLES}) begin
            n_fail++;
            $display("FAIL zero_stable: got done=%0b err=%0b after %0d cycles want 1 0 after %0d",
                     bus.done, bus.err, t, HALT_CYCLES);
        end
        start_run(0);
        drive(3, 0);
        n_checks++;
        if ({bus.err, bus.err_kind, bus.err_idx} !== {1'b1, 2'd3, 3'd0}) begin
            n_fail++;
            $display("FAIL zero_change: got err=%0b kind=%0d idx=%0d want 1 3 0", bus.err, bus.err_kind, bus.err_idx);
        end
    endtask

    task automatic test_reset_midrun();
        int t;
        start_run(5);
        run_good(2);
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({bus.busy, bus.done, bus.err, bus.err_kind, bus.err_idx, bus.event_count} !== '0) begin
            n_fail++;
            $display("FAIL async_reset_midrun: got busy=%0b done=%0b err=%0b cnt=%0d want all 0",
                     bus.busy, bus.done, bus.err, bus.event_count);
        end
        #2 reset = 1'b0;
        tick();
        start_run(5);
        run_good(5);
        wait_end(40, t);
        n_checks++;
        if ({bus.done, bus.err, bus.event_count} !== {1'b1, 1'b0, 4'd5}) begin
            n_fail++;
            $display("FAIL rerun_after_reset: got done=%0b err=%0b cnt=%0d want 1 0 5", bus.done, bus.err, bus.event_count);
        end
    endtask

    task automatic test_cfg_while_busy();
        int t;
        start_run(5);
        bus.cfg_addr = 3'd2;
        bus.cfg_pc   = 9'd9;
        bus.cfg_data = 16'd0;
        bus.cfg_chk  = 1'b0;
        bus.cfg_we   = 1'b1;
        drive(1, 0);
        drive(2, 5);
        bus.cfg_we   = 1'b0;
        drive(3, 16'hABCD);
        run_good(5);
        wait_end(40, t);
        start_run(5);
        run_good(5);
        wait_end(40, t);
        n_checks++;
        if ({bus.done, bus.err} !== 2'b10) begin
            n_fail++;
            $display("FAIL cfg_locked_while_busy: got done=%0b err=%0b kind=%0d idx=%0d want done=1 err=0",
                     bus.done, bus.err, bus.err_kind, bus.err_idx);
        end
    endtask

    task automatic test_clamp();
        int t;
        write_entry(5, 6, 0, 1'b0);
        write_entry(6, 7, 0, 1'b0);
        write_entry(7, 8, 0, 1'b0);
        start_run(9);
        run_good(8);
        n_checks++;
        if ({bus.event_count, bus.busy, bus.err} !== {4'd8, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL clamp_events: got cnt=%0d busy=%0b err=%0b want 8 1 0", bus.event_count, bus.busy, bus.err);
        end
        wait_end(40, t);
        n_checks++;
        if ({bus.done, bus.err, t} !== {1'b1, 1'b0, HALT_CYCLES}) begin
            n_fail++;
            $display("FAIL clamp_done: got done=%0b err=%0b after %0d want 1 0 after %0d", bus.done, bus.err, t, HALT_CYCLES);
        end
    endtask

    initial begin
        bus.cfg_we      = 1'b0;
        bus.cfg_addr    = 3'd0;
        bus.cfg_pc      = 9'd0;
        bus.cfg_data    = 16'd0;
        bus.cfg_chk     = 1'b0;
        bus.num_entries = 4'd0;
        bus.start       = 1'b0;
        bus.pc          = 9'd0;
        bus.probe_data  = 16'd0;
        test_reset();
        write_entry(0, 1, 0, 1'b0);
        write_entry(1, 2, 5, 1'b1);
        write_entry(2, 3, 16'hABCD, 1'b1);
        write_entry(3, 4, 0, 1'b0);
        write_entry(4, 5, 0, 1'b0);
        test_pass();
        test_pc_mismatch();
        test_data_mismatch();
        test_stall();
        test_late_change();
        test_zero_entries();
        test_reset_midrun();
        test_cfg_while_busy();
        test_clamp();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
